// File: rtl/pmem_arbiter.sv
`timescale 1ns/1ps
// pmem_arbiter
//   Shares the single physical-memory port between the instruction cache and
//   the data cache. Exactly one whole-line transaction is in flight at a time.
//   The winner's request is latched into the mem_* registers at grant and held
//   until mem_resp. One idle GAP cycle follows every transaction so the served
//   cache can drop its request before requests are sampled again.
//
//   Optional feature macro: PMEM_ARB_RR_EN
//     defined   : round-robin between I and D when both request in IDLE
//     undefined : fixed priority, dcache over icache
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   i_pmem_read / i_pmem_address     icache line read request
//   i_pmem_rdata / i_pmem_resp       icache line data / transaction done
//   d_pmem_read / d_pmem_write       dcache line read / writeback request
//   d_pmem_address / d_pmem_wdata    dcache line address / writeback line
//   d_pmem_rdata / d_pmem_resp       dcache line data / transaction done
//   mem_read / mem_write             registered physical-memory op strobes
//   mem_address / mem_wdata          registered address / write line
//   mem_rdata / mem_resp             memory read line / 1-cycle done pulse
//   busy                             arbiter is not in IDLE
module pmem_arbiter #(
  parameter int s_line = 256,
  parameter int s_addr = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [s_addr-1:0] i_pmem_address,
  output logic [s_line-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [s_addr-1:0] d_pmem_address,
  input  logic [s_line-1:0] d_pmem_wdata,
  output logic [s_line-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [s_addr-1:0] mem_address,
  output logic [s_line-1:0] mem_wdata,
  input  logic [s_line-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, GAP} state_t;

  // Latched memory request; this is the entire registered memory-side view.
  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [s_addr-1:0] addr;
    logic [s_line-1:0] wdata;
  } mreq_t;

  state_t state, state_nx;
  mreq_t  mreq, mreq_nx;

  logic d_req, i_req;
  logic grant_d, grant_i;

  assign d_req = d_pmem_read | d_pmem_write;
  assign i_req = i_pmem_read;

`ifdef PMEM_ARB_RR_EN
  typedef enum logic {CLI_I, CLI_D} cli_t;
  cli_t last_grant;

  // Contested grant goes to whoever was not served last.
  assign grant_d = (state == IDLE) & d_req & (~i_req | (last_grant == CLI_I));

  always_ff @(posedge clk) begin
    if (rst)          last_grant <= CLI_D;
    else if (grant_d) last_grant <= CLI_D;
    else if (grant_i) last_grant <= CLI_I;
  end
`else
  // Fixed priority: dcache always beats icache.
  assign grant_d = (state == IDLE) & d_req;
`endif

  assign grant_i = (state == IDLE) & i_req & ~grant_d;

  always_comb begin
    state_nx = state;
    mreq_nx  = mreq;
    case (state)
      IDLE: begin
        mreq_nx.rd = 1'b0;
        mreq_nx.wr = 1'b0;
        if (grant_d) begin
          state_nx      = SERVE_D;
          mreq_nx.addr  = d_pmem_address;
          mreq_nx.wdata = d_pmem_wdata;
          // Read+write together is illegal; the writeback wins.
          mreq_nx.wr    = d_pmem_write;
          mreq_nx.rd    = ~d_pmem_write;
        end else if (grant_i) begin
          state_nx     = SERVE_I;
          mreq_nx.addr = i_pmem_address;
          mreq_nx.rd   = 1'b1;
        end
      end
      SERVE_I, SERVE_D: begin
        // Client inputs are ignored here; only mem_resp ends the service.
        if (mem_resp) begin
          state_nx   = GAP;
          mreq_nx.rd = 1'b0;
          mreq_nx.wr = 1'b0;
        end
      end
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mreq  <= '0;
    end else begin
      state <= state_nx;
      mreq  <= mreq_nx;
    end
  end

  assign mem_read    = mreq.rd;
  assign mem_write   = mreq.wr;
  assign mem_address = mreq.addr;
  assign mem_wdata   = mreq.wdata;

  // Responses are gated by the serving state, so a stale or spurious mem_resp
  // in IDLE/GAP (or after a reset aborted a transaction) reaches nobody.
  assign i_pmem_resp  = mem_resp & (state == SERVE_I);
  assign d_pmem_resp  = mem_resp & (state == SERVE_D);
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;
  assign busy         = (state != IDLE);

`ifndef SYNTHESIS
  // Protocol check on the dcache: read and write must never be raised together.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE)
      assert (!(d_pmem_read && d_pmem_write))
      else $warning("pmem_arbiter: dcache raised read and write together");
  end
`endif

endmodule
